// File: rtl/wb_stage_ext.sv
// Writeback stage: registers the MEM->WB payload, selects and extends writeback data,
// drives the register-file write port, eret_w, and a retired-instruction counter.
module wb_stage_ext #(
    parameter int DATA_W = 32,
    parameter int REG_AW = 5,
    parameter int CNT_W  = 32
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              stall_w,
    input  logic              flush_w,
    input  logic              m_valid,
    input  logic [DATA_W-1:0] m_pc4,
    input  logic [DATA_W-1:0] m_alu,
    input  logic [DATA_W-1:0] m_dm,
    input  logic [REG_AW-1:0] m_a3,
    input  logic              m_regwrite,
    input  logic [1:0]        m_wbsel,
    input  logic [2:0]        m_ldtype,
    input  logic              m_eret,
    output logic              w_valid,
    output logic              w_regwrite,
    output logic [REG_AW-1:0] w_a3,
    output logic [DATA_W-1:0] w_wd,
    output logic [DATA_W-1:0] w_pc4,
    output logic              eret_w,
    output logic [CNT_W-1:0]  retired_cnt
);

    typedef enum logic [1:0] {
        WB_ALU = 2'd0,
        WB_DM  = 2'd1,
        WB_PC8 = 2'd2,
        WB_RSV = 2'd3
    } wbsel_e;

    typedef enum logic [2:0] {
        LD_W  = 3'd0,
        LD_B  = 3'd1,
        LD_BU = 3'd2,
        LD_H  = 3'd3,
        LD_HU = 3'd4
    } ldtype_e;

    logic              valid_q;
    logic              regwrite_q;
    logic              eret_q;
    logic [REG_AW-1:0] a3_q;
    logic [DATA_W-1:0] pc4_q;
    logic [DATA_W-1:0] alu_q;
    logic [DATA_W-1:0] dm_q;
    wbsel_e            wbsel_q;
    logic [2:0]        ldtype_q;
    logic [CNT_W-1:0]  cnt_q;

    // NOTE: async reset sits in the sensitivity list so outputs clear immediately, not at the next edge.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            valid_q    <= 1'b0;
            regwrite_q <= 1'b0;
            eret_q     <= 1'b0;
            a3_q       <= '0;
            pc4_q      <= '0;
            alu_q      <= '0;
            dm_q       <= '0;
            wbsel_q    <= WB_ALU;
            ldtype_q   <= '0;
        end else if (flush_w) begin
            valid_q    <= 1'b0;
            regwrite_q <= 1'b0;
            eret_q     <= 1'b0;
            a3_q       <= '0;
            pc4_q      <= '0;
            alu_q      <= '0;
            dm_q       <= '0;
            wbsel_q    <= WB_ALU;
            ldtype_q   <= '0;
        end else if (!stall_w) begin
            valid_q    <= m_valid;
            regwrite_q <= m_regwrite;
            eret_q     <= m_eret;
            a3_q       <= m_a3;
            pc4_q      <= m_pc4;
            alu_q      <= m_alu;
            dm_q       <= m_dm;
            wbsel_q    <= wbsel_e'(m_wbsel);
            ldtype_q   <= m_ldtype;
        end
    end

    // An instruction retires when it leaves W; a flush in the same cycle does not cancel that.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt_q <= '0;
        end else if (valid_q && !stall_w) begin
            cnt_q <= cnt_q + CNT_W'(1);
        end
    end

    logic [7:0]        ld_byte;
    logic [15:0]       ld_half;
    logic [DATA_W-1:0] ld_data;
    logic [DATA_W-1:0] wd;

    // NOTE: every combinational output gets a default first so no path can infer a latch.
    always_comb begin
        ld_byte = dm_q[7:0];
        unique case (alu_q[1:0])
            2'd0: ld_byte = dm_q[7:0];
            2'd1: ld_byte = dm_q[15:8];
            2'd2: ld_byte = dm_q[23:16];
            2'd3: ld_byte = dm_q[31:24];
        endcase
        // offset[0] is ignored for halfwords; misalignment is trapped upstream
        ld_half = alu_q[1] ? dm_q[31:16] : dm_q[15:0];

        ld_data = dm_q;
        case (ldtype_q)
            LD_B:    ld_data = {{(DATA_W-8){ld_byte[7]}}, ld_byte};
            LD_BU:   ld_data = {{(DATA_W-8){1'b0}}, ld_byte};
            LD_H:    ld_data = {{(DATA_W-16){ld_half[15]}}, ld_half};
            LD_HU:   ld_data = {{(DATA_W-16){1'b0}}, ld_half};
            default: ld_data = dm_q;
        endcase

        wd = '0;
        unique case (wbsel_q)
            WB_ALU: wd = alu_q;
            WB_DM:  wd = ld_data;
            WB_PC8: wd = pc4_q + DATA_W'(4);
            WB_RSV: wd = '0;
        endcase
    end

    assign w_valid     = valid_q;
    assign w_regwrite  = valid_q & regwrite_q & (a3_q != '0);
    assign w_a3        = a3_q;
    assign w_wd        = wd;
    assign w_pc4       = pc4_q;
    assign eret_w      = valid_q & eret_q;
    assign retired_cnt = cnt_q;

endmodule
